// File: rtl/fir_xifu_pkg.sv
// Shared FIR XIFU types: the regfile write-port struct and the writeback request
// carried by each writeback source slot.
package fir_xifu_pkg;

  localparam int XIFU_RD_W   = 5;
  localparam int XIFU_DATA_W = 32;

  localparam int WB_SRC_EX  = 0;
  localparam int WB_SRC_MEM = 1;

  typedef struct packed {
    logic                   write;
    logic [XIFU_RD_W-1:0]   rd;
    logic [XIFU_DATA_W-1:0] result;
  } wb2regfile_t;

  typedef struct packed {
    logic [XIFU_RD_W-1:0]   rd;
    logic [XIFU_DATA_W-1:0] result;
  } wb_req_t;

endpackage

// File: rtl/fir_xifu_wb_slot.sv
// One-entry writeback buffer. It accepts a new request when empty or when
// its current entry is being granted, so a granted slot can refill on the same edge.
module fir_xifu_wb_slot
  import fir_xifu_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    valid_i,
  output logic    ready_o,
  input  wb_req_t req_i,
  input  logic    grant_i,
  output logic    slot_valid_o,
  output wb_req_t slot_req_o
);

  logic    valid_q, valid_d;
  wb_req_t req_q, req_d;

  assign ready_o      = ~valid_q | grant_i;
  assign slot_valid_o = valid_q;
  assign slot_req_o   = req_q;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (valid_i && ready_o) begin
      valid_d = 1'b1;
      req_d   = req_i;
    end else if (grant_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid_q everywhere it is used, so it needs no reset.
  always_ff @(posedge clk_i) begin
    req_q <= req_d;
  end

endmodule

// File: rtl/fir_xifu_wb_arbiter.sv
// Arbitrates the XIFU regfile write port between the EX result and the XIF load response.
// Define FIR_XIFU_WB_RR_EN for round-robin on different-rd contention; default is MEM > EX.
module fir_xifu_wb_arbiter
  import fir_xifu_pkg::*;
#(
  parameter int NB_REGS = 4,
  parameter int RD_W    = XIFU_RD_W,
  parameter int DATA_W  = XIFU_DATA_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic [RD_W-1:0]    ex_rd_i,
  input  logic [DATA_W-1:0]  ex_result_i,
  input  logic               mem_valid_i,
  output logic               mem_ready_o,
  input  logic [RD_W-1:0]    mem_rd_i,
  input  logic [DATA_W-1:0]  mem_result_i,
  output wb2regfile_t        wb2regfile_o,
  output logic [NB_REGS-1:0] pending_o,
  output logic               busy_o
);

  localparam int              IDX_W    = $clog2(NB_REGS);
  localparam logic [RD_W:0]   RD_LIMIT = (RD_W+1)'(NB_REGS);

  function automatic logic [NB_REGS-1:0] rd_decode(input logic vld, input logic [RD_W-1:0] rd);
    logic [NB_REGS-1:0] oh;
    oh = '0;
    if (vld && ({1'b0, rd} < RD_LIMIT)) begin
      oh[rd[IDX_W-1:0]] = 1'b1;
    end
    return oh;
  endfunction

  wb_req_t ex_req_in, mem_req_in;
  wb_req_t ex_req, mem_req;
  logic    ex_vld, mem_vld;
  logic    grant_ex, grant_mem;

  assign ex_req_in  = '{rd: ex_rd_i,  result: ex_result_i};
  assign mem_req_in = '{rd: mem_rd_i, result: mem_result_i};

  fir_xifu_wb_slot u_ex_slot (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (ex_valid_i),
    .ready_o      (ex_ready_o),
    .req_i        (ex_req_in),
    .grant_i      (grant_ex),
    .slot_valid_o (ex_vld),
    .slot_req_o   (ex_req)
  );

  fir_xifu_wb_slot u_mem_slot (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (mem_valid_i),
    .ready_o      (mem_ready_o),
    .req_i        (mem_req_in),
    .grant_i      (grant_mem),
    .slot_valid_o (mem_vld),
    .slot_req_o   (mem_req)
  );

`ifdef FIR_XIFU_WB_RR_EN
  // rr_q records the source that won the last contended grant; the other source goes next.
  logic rr_q, rr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'(WB_SRC_EX);
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Grant looks only at slot state, which keeps valid_i out of the ready_o cone.
  always_comb begin
    grant_ex  = 1'b0;
    grant_mem = 1'b0;
`ifdef FIR_XIFU_WB_RR_EN
    rr_d      = rr_q;
`endif
    if (ex_vld && mem_vld) begin
      if (ex_req.rd == mem_req.rd) begin
        // Load first so the younger EX value is the one left in the register.
        grant_mem = 1'b1;
`ifdef FIR_XIFU_WB_RR_EN
      end else if (rr_q == 1'(WB_SRC_MEM)) begin
        grant_ex = 1'b1;
`endif
      end else begin
        grant_mem = 1'b1;
      end
`ifdef FIR_XIFU_WB_RR_EN
      rr_d = grant_mem ? 1'(WB_SRC_MEM) : 1'(WB_SRC_EX);
`endif
    end else begin
      grant_ex  = ex_vld;
      grant_mem = mem_vld;
    end
  end

  always_comb begin
    wb2regfile_o = '0;
    if (grant_mem) begin
      wb2regfile_o.write  = 1'b1;
      wb2regfile_o.rd     = mem_req.rd;
      wb2regfile_o.result = mem_req.result;
    end else if (grant_ex) begin
      wb2regfile_o.write  = 1'b1;
      wb2regfile_o.rd     = ex_req.rd;
      wb2regfile_o.result = ex_req.result;
    end
  end

  assign pending_o = rd_decode(ex_vld, ex_req.rd) | rd_decode(mem_vld, mem_req.rd);
  assign busy_o    = ex_vld | mem_vld;

endmodule
